// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: picorv32 native memory bus to single-port 1024x32 SRAM bridge.
// The SRAM macro has no byte enables, so partial-word writes are performed as
// read-modify-write. All outputs are registered.
//
// Ports:
//   clk        system clock, also the SRAM clock
//   resetn     asynchronous active-low reset
//   mem_valid  request valid (CPU side)
//   mem_ready  one-cycle completion pulse
//   mem_addr   byte address; only [ADDR_LSB+AW-1:ADDR_LSB] is used
//   mem_wdata  write data
//   mem_wstrb  byte write strobes, 0 = read
//   mem_rdata  read data, valid while mem_ready=1, holds last read value
//   sram_a     SRAM word address
//   sram_d     SRAM write data
//   sram_cen   SRAM chip enable, active-low
//   sram_wen   SRAM write enable, active-low
//   sram_oen   SRAM output enable, active-low
//   sram_q     SRAM read data
module sram_bus_ctrl #(
    parameter int unsigned AW       = 10,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_rdata,
    output logic [AW-1:0] sram_a,
    output logic [31:0]   sram_d,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic          sram_oen,
    input  logic [31:0]   sram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_CAP,
        S_WR,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [31:0]   d_q, d_d;
    logic          cen_q, cen_d;
    logic          wen_q, wen_d;
    logic          oen_q, oen_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          rmw_q, rmw_d;

    // Address bits above/below the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        cen_d   = cen_q;
        wen_d   = wen_q;
        oen_d   = oen_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rmw_d   = rmw_q;

        case (state_q)
            S_IDLE: begin
                if (mem_valid && !ready_q) begin
                    a_d     = mem_addr[ADDR_LSB+AW-1:ADDR_LSB];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    cen_d   = 1'b0;
                    if (mem_wstrb == 4'hF) begin
                        wen_d   = 1'b0;
                        oen_d   = 1'b1;
                        d_d     = mem_wdata;
                        rmw_d   = 1'b0;
                        state_d = S_WR;
                    end else begin
                        // Reads and partial writes both start with an SRAM read.
                        wen_d   = 1'b1;
                        oen_d   = 1'b0;
                        rmw_d   = (mem_wstrb != '0);
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                // cen stays low: a rising cen would clear Q before capture.
                oen_d   = 1'b1;
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                if (rmw_q) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        d_d[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : sram_q[8*i +: 8];
                    end
                    wen_d   = 1'b0;
                    state_d = S_WR;
                end else begin
                    rdata_d = sram_q;
                    ready_d = 1'b1;
                    cen_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                cen_d   = 1'b1;
                wen_d   = 1'b1;
                ready_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            d_q     <= '0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            oen_q   <= 1'b1;
            ready_q <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rmw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            oen_q   <= oen_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rmw_q   <= rmw_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign sram_a    = a_q;
    assign sram_d    = d_q;
    assign sram_cen  = cen_q;
    assign sram_wen  = wen_q;
    assign sram_oen  = oen_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Testbench for sram_bus_ctrl: behavioural SRAM plus a word-array reference
// model of memory contents, latencies and per-transaction SRAM access counts.
module tb_sram_bus_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic [9:0]  sram_a;
    logic [31:0] sram_d;
    logic        sram_cen;
    logic        sram_wen;
    logic        sram_oen;
    logic [31:0] sram_q;

    always #5 clk = ~clk;

    sram_bus_ctrl #(.AW(10), .ADDR_LSB(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_oen  (sram_oen),
        .sram_q    (sram_q)
    );

    // Behavioural SRAM: synchronous access, Q cleared while/when CEn is high.
    logic [31:0] sram_mem [1024];
    int          sram_rd_cnt = 0;
    int          sram_wr_cnt = 0;

    always @(posedge clk or posedge sram_cen) begin
        if (sram_cen) begin
            sram_q <= '0;
        end else if (!sram_wen) begin
            sram_mem[sram_a] <= sram_d;
            sram_wr_cnt      <= sram_wr_cnt + 1;
        end else if (!sram_oen) begin
            sram_q      <= sram_mem[sram_a];
            sram_rd_cnt <= sram_rd_cnt + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model
    logic [31:0] ref_mem [1024];
    logic [31:0] last_rd;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One bus transaction; returns the cycle count at which mem_ready was seen.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit hold, output int rdy_cyc);
        int          n;
        int          lat;
        bit          acc;
        bit          rdy;
        int          rd0;
        int          wr0;
        int unsigned idx;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [31:0] merged;

        idx     = (addr >> 2) & 32'h3FF;
        exp_lat = (strb == 4'h0) ? 2 : ((strb == 4'hF) ? 1 : 3);
        rd0     = sram_rd_cnt;
        wr0     = sram_wr_cnt;
        rdy_cyc = 0;

        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;

        acc = 0;
        n   = 0;
        while (!acc && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (sram_cen == 1'b0) acc = 1;
        end
        check("accept", {31'd0, acc}, 32'd1);
        if (!acc) begin
            mem_valid = 1'b0;
            return;
        end
        check("sram_a", {22'd0, sram_a}, idx);

        // Request changes after acceptance must be ignored.
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
        if (!hold) mem_valid = 1'($urandom_range(0, 1));

        lat = 0;
        rdy = 0;
        while (!rdy && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (mem_ready) rdy = 1;
            else check("cen_held", {31'd0, sram_cen}, 32'd0);
        end
        check("ready_seen", {31'd0, rdy}, 32'd1);
        check("latency", lat, exp_lat);
        rdy_cyc = cyc;

        if (strb == 4'h0) begin
            exp_rd  = ref_mem[idx];
            last_rd = exp_rd;
        end else begin
            exp_rd = last_rd;
            merged = ref_mem[idx];
            for (int b = 0; b < 4; b++)
                if (strb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[idx] = merged;
        end
        check("rdata", mem_rdata, exp_rd);
        check("rd_count", sram_rd_cnt - rd0, (strb == 4'hF) ? 0 : 1);
        check("wr_count", sram_wr_cnt - wr0, (strb == 4'h0) ? 0 : 1);
        check("cen_idle", {31'd0, sram_cen}, 32'd1);
        check("wen_idle", {31'd0, sram_wen}, 32'd1);

        if (!hold) mem_valid = 1'b0;
        // DONE cycle: pulse drops, and no request is accepted here.
        @(posedge clk); #1;
        check("ready_pulse", {31'd0, mem_ready}, 32'd0);
        check("no_accept_done", {31'd0, sram_cen}, 32'd1);
    endtask

    int rc;
    int prev_rc;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        last_rd   = '0;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cen", {31'd0, sram_cen}, 32'd1);
        check("rst_wen", {31'd0, sram_wen}, 32'd1);
        check("rst_oen", {31'd0, sram_oen}, 32'd1);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_a", {22'd0, sram_a}, 32'd0);
        check("rst_d", sram_d, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Seed the word pool 0..15 with known contents.
        for (int i = 0; i < 16; i++) txn(32'(i) << 2, $urandom, 4'hF, 1'b0, rc);

        // Directed cases
        txn(32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, rc);
        txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, rc);
        check("deadbeef", last_rd, 32'hDEADBEEF);
        txn(32'h0000_0020, 32'h11223344, 4'hF, 1'b0, rc);
        txn(32'h0000_0020, 32'hAABBCCDD, 4'b0101, 1'b0, rc);
        txn(32'h0000_0020, 32'h0, 4'h0, 1'b0, rc);
        check("rmw_value", last_rd, 32'h11BB33DD);
        txn(32'h0000_1004, 32'h5A5A5A5A, 4'hF, 1'b0, rc);
        txn(32'h0000_0004, 32'h0, 4'h0, 1'b0, rc);
        check("wrap_value", last_rd, 32'h5A5A5A5A);

        // Reset while a partial write sits in RD_CAP: memory must stay intact.
        txn(32'h0000_0030, 32'h12345678, 4'hF, 1'b0, rc);
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0030;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'b0011;
        begin
            bit acc = 0;
            for (int n = 0; n < 20 && !acc; n++) begin
                @(posedge clk); #1;
                if (sram_cen == 1'b0) acc = 1;
            end
            check("rst_mid_accept", {31'd0, acc}, 32'd1);
        end
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("async_cen", {31'd0, sram_cen}, 32'd1);
        check("async_wen", {31'd0, sram_wen}, 32'd1);
        check("async_oen", {31'd0, sram_oen}, 32'd1);
        check("async_ready", {31'd0, mem_ready}, 32'd0);
        check("async_rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        last_rd   = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        txn(32'h0000_0030, 32'h0, 4'h0, 1'b0, rc);
        check("rst_mid_keep", last_rd, 32'h12345678);

        // Back-to-back reads with mem_valid held high.
        prev_rc = 0;
        for (int i = 0; i < 4; i++) begin
            txn(32'(i + 4) << 2, 32'h0, 4'h0, 1'b1, rc);
            if (i > 0) check("b2b_spacing", rc - prev_rc, 32'd4);
            prev_rc = rc;
        end
        mem_valid = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic over the seeded pool with random upper address bits.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [3:0]  s;
            int          kind;
            a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
            kind = $urandom_range(0, 2);
            s    = (kind == 0) ? 4'h0 : ((kind == 1) ? 4'hF : 4'($urandom_range(1, 14)));
            txn(a, $urandom, s, 1'($urandom_range(0, 1)), rc);
        end
        mem_valid = 1'b0;

        // Final sweep: every pool word must match the model.
        for (int i = 0; i < 16; i++) txn(32'(i) << 2, 32'h0, 4'h0, 1'b0, rc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
